// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS multi-cycle control slice:
// opcodes, functs, ALU codes, mux selects and the control state enum.
package mips16_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_SLT = 4'd4;
  localparam logic [3:0] F_JR  = 4'd8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OC_ADD   = 2'd0,
    OC_SLT   = 2'd1,
    OC_RTYPE = 2'd2
  } opclass_t;

endpackage

// File: rtl/mips16_alu_decoder.sv
// Maps {op class, funct} to an ALU control code and flags undefined functs.
// Ports: i_opclass, i_funct in; o_alu_ctrl, o_illegal out.
module mips16_alu_decoder
  import mips16_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int ALUC_W  = 3
) (
  input  opclass_t            i_opclass,
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic [ALUC_W-1:0]   o_alu_ctrl,
  output logic                o_illegal
);

  always_comb begin
    o_alu_ctrl = ALUC_W'(ALU_ADD);
    o_illegal  = 1'b0;
    unique case (i_opclass)
      OC_SLT: o_alu_ctrl = ALUC_W'(ALU_SLT);
      OC_RTYPE: begin
        unique case (1'b1)
          (i_funct == FUNCT_W'(F_ADD)): o_alu_ctrl = ALUC_W'(ALU_ADD);
          (i_funct == FUNCT_W'(F_SUB)): o_alu_ctrl = ALUC_W'(ALU_SUB);
          (i_funct == FUNCT_W'(F_AND)): o_alu_ctrl = ALUC_W'(ALU_AND);
          (i_funct == FUNCT_W'(F_OR)):  o_alu_ctrl = ALUC_W'(ALU_OR);
          (i_funct == FUNCT_W'(F_SLT)): o_alu_ctrl = ALUC_W'(ALU_SLT);
          // jr never reaches EXEC; the code is a don't-care
          (i_funct == FUNCT_W'(F_JR)):  o_alu_ctrl = ALUC_W'(ALU_ADD);
          default:                      o_illegal  = 1'b1;
        endcase
      end
      default: o_alu_ctrl = ALUC_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/wb with a
// memory-ready watchdog; drives all datapath strobes from state+IR fields.
module mips16_multicycle_ctrl
  import mips16_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int FUNCT_W  = 4,
  parameter int ALUC_W   = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_eq,
  output logic                pc_write_ne,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUC_W-1:0]   alu_ctrl,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_fault;

  logic            w_r, w_slti, w_j, w_bne;
  logic            w_lw, w_sw, w_beq, w_jr;
  logic            w_tmo, w_wait;
  opclass_t        w_class;
  logic [ALUC_W-1:0] w_ex_aluc;
  logic            w_bad_funct;

  assign w_r    = opcode == OPCODE_W'(OP_R);
  assign w_slti = opcode == OPCODE_W'(OP_SLTI);
  assign w_j    = opcode == OPCODE_W'(OP_J);
  assign w_bne  = opcode == OPCODE_W'(OP_BNE);
  assign w_lw   = opcode == OPCODE_W'(OP_LW);
  assign w_sw   = opcode == OPCODE_W'(OP_SW);
  assign w_beq  = opcode == OPCODE_W'(OP_BEQ);
  assign w_jr   = w_r && (funct == FUNCT_W'(F_JR));

  assign w_class = w_r    ? OC_RTYPE :
                   w_slti ? OC_SLT   : OC_ADD;

  mips16_alu_decoder #(
    .FUNCT_W (FUNCT_W),
    .ALUC_W  (ALUC_W)
  ) u_alu_dec (
    .i_opclass  (w_class),
    .i_funct    (funct),
    .o_alu_ctrl (w_ex_aluc),
    .o_illegal  (w_bad_funct)
  );

  // Ready arriving on the count==WAIT_MAX cycle still wins over timeout.
  assign w_tmo  = (WAIT_MAX != 0) && (r_cnt == CW'(WAIT_MAX));
  assign w_wait = ((r_state == S_FETCH) && !imem_ready) ||
                  ((r_state == S_MEM)   && !dmem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= r_fault | (w_next == S_FAULT);
      if ((w_next == S_FETCH || w_next == S_MEM) && w_next != r_state)
        r_cnt <= '0;
      else if (w_wait && r_cnt != {CW{1'b1}})
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Outputs are forced low while reset is high so an in-flight access
  // is dropped in the same cycle reset asserts.
  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_src      = PC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_ctrl    = ALUC_W'(ALU_ADD);
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          imem_req  = 1'b1;
          alu_src_b = SRCB_TWO;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else if (w_tmo) begin
            w_next   = S_FAULT;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          if (w_beq || w_bne) begin
            w_next = S_BRANCH;
          end else if (w_j || w_jr) begin
            w_next = S_JUMP;
          end else if (w_r && w_bad_funct) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = w_r ? SRCB_RT : SRCB_IMM;
          alu_ctrl  = w_ex_aluc;
          w_next    = (w_lw || w_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = w_lw;
          mem_write = w_sw;
          if (dmem_ready) begin
            instr_done = w_sw;
            w_next     = w_lw ? S_WB : S_FETCH;
          end else if (w_tmo) begin
            w_next = S_FAULT;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = w_r;
          mem_to_reg = w_lw;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_RT;
          alu_ctrl    = ALUC_W'(ALU_SUB);
          pc_src      = PC_ALUOUT;
          pc_write_eq = w_beq;
          pc_write_ne = w_bne;
          instr_done  = 1'b1;
          w_next      = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = w_jr ? PC_RS : PC_JUMP;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_FAULT: w_next = S_FAULT;
      endcase
    end
  end

  assign fault = r_fault & ~reset;
  assign state = reset ? 3'(S_FETCH) : 3'(r_state);

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// Directed bench for mips16_multicycle_ctrl with WAIT_MAX=4:
// latency/strobe sequences, watchdog boundary, fault and reset abort.
module tb_mips16_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       imem_ready, dmem_ready;
  logic       imem_req, dmem_req, mem_read, mem_write;
  logic       ir_write, pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_dst, mem_to_reg, reg_write;
  logic       instr_done, illegal, fault;
  logic [2:0] state;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mips16_multicycle_ctrl #(
    .OPCODE_W (3),
    .FUNCT_W  (4),
    .ALUC_W   (3),
    .WAIT_MAX (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_write_eq (pc_write_eq),
    .pc_write_ne (pc_write_ne),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl    (alu_ctrl),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .fault       (fault),
    .state       (state)
  );

  // write-type strobes: ir,pc,eq,ne,rw,mw,mr,dreq,ireq
  logic [8:0] wr;
  assign wr = {ir_write, pc_write, pc_write_eq, pc_write_ne,
               reg_write, mem_write, mem_read, dmem_req, imem_req};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // advance one clock; outputs are sampled 2 time units after the edge
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    opcode = 3'd0;
    funct = 4'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    tick; tick;
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(wr), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_done", 32'({instr_done, illegal}), 0);

    reset = 1'b0;
    #1;
    chk("post_rst_ireq", 32'(imem_req), 1);

    // add, readies high: 0,1,2,4 then back to 0
    opcode = 3'd0; funct = 4'd0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("add_c1_state", 32'(state), 0);
    chk("add_c1_wr", 32'(wr), 9'b110000001);
    chk("add_c1_srcb", 32'(alu_src_b), 1);
    tick;
    chk("add_c2_state", 32'(state), 1);
    chk("add_c2_srcb", 32'(alu_src_b), 3);
    chk("add_c2_wr", 32'(wr), 0);
    tick;
    chk("add_c3_state", 32'(state), 2);
    chk("add_c3_src", 32'({alu_src_a, alu_src_b, alu_ctrl}), 6'b100000);
    chk("add_c3_rw", 32'({reg_write, instr_done}), 0);
    tick;
    chk("add_c4_state", 32'(state), 4);
    chk("add_c4_wb", 32'({reg_write, reg_dst, mem_to_reg, instr_done}),
        4'b1101);
    tick;
    chk("add_end_state", 32'(state), 0);

    // sub in EXEC
    funct = 4'd1;
    tick; tick;
    chk("sub_exec_alu", 32'(alu_ctrl), 1);
    tick; tick;

    // lw with dmem_ready low 3 cycles: 8 cycles total
    opcode = 3'd4; funct = 4'd0;
    dmem_ready = 1'b0;
    #1;
    chk("lw_c1_state", 32'(state), 0);
    tick;
    chk("lw_c2_state", 32'(state), 1);
    tick;
    chk("lw_c3_state", 32'(state), 2);
    chk("lw_c3_src", 32'({alu_src_a, alu_src_b, alu_ctrl}), 6'b110000);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lw_mem%0d", i), 32'({state, dmem_req, mem_read, mem_write}),
          6'b011110);
      tick;
    end
    dmem_ready = 1'b1;
    #1;
    chk("lw_mem3", 32'({state, dmem_req, mem_read, mem_write, instr_done}),
        7'b0111100);
    tick;
    dmem_ready = 1'b0;
    #1;
    chk("lw_wb_state", 32'(state), 4);
    chk("lw_wb", 32'({reg_write, reg_dst, mem_to_reg, instr_done}), 4'b1011);
    tick;
    chk("lw_end_state", 32'(state), 0);

    // beq
    opcode = 3'd6;
    tick;
    chk("beq_dec_state", 32'(state), 1);
    tick;
    chk("beq_br_state", 32'(state), 5);
    chk("beq_br_alu", 32'({alu_src_a, alu_src_b, alu_ctrl, pc_src}),
        8'b10000101);
    chk("beq_br_wr", 32'(wr), 9'b001000000);
    chk("beq_br_done", 32'(instr_done), 1);
    tick;
    chk("beq_end_state", 32'(state), 0);

    // bne
    opcode = 3'd3;
    tick; tick;
    chk("bne_br_state", 32'(state), 5);
    chk("bne_br_wr", 32'(wr), 9'b000100000);
    chk("bne_br_ctl", 32'({alu_ctrl, pc_src, instr_done}), 6'b001011);
    tick;

    // jr
    opcode = 3'd0; funct = 4'd8;
    tick; tick;
    chk("jr_state", 32'(state), 6);
    chk("jr_ctl", 32'({pc_write, pc_src, instr_done}), 4'b1111);
    chk("jr_wr", 32'(wr), 9'b010000000);
    tick;

    // j
    opcode = 3'd2; funct = 4'd0;
    tick; tick;
    chk("j_ctl", 32'({state, pc_write, pc_src, instr_done}), 7'b1101101);
    tick;

    // illegal funct 5
    opcode = 3'd0; funct = 4'd5;
    tick;
    chk("ill_dec", 32'({state, illegal, instr_done}), 5'b00111);
    chk("ill_wr", 32'(wr), 0);
    tick;
    chk("ill_back", 32'({state, illegal, instr_done}), 0);

    // slti with imem ready arriving exactly at count==WAIT_MAX
    opcode = 3'd1; funct = 4'd0;
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) tick;
    imem_ready = 1'b1;
    #1;
    chk("bnd_accept", 32'({state, ir_write, fault}), 5'b00010);
    tick;
    chk("bnd_dec", 32'({state, fault}), 4'b0010);
    tick;
    chk("slti_exec", 32'({alu_src_a, alu_src_b, alu_ctrl}), 6'b110100);
    tick;
    chk("slti_wb", 32'({state, reg_write, reg_dst, mem_to_reg}), 6'b100100);
    tick;

    // watchdog: imem never ready
    imem_ready = 1'b0;
    opcode = 3'd0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tmo_fetch%0d", i), 32'({state, imem_req, fault}),
          5'b00010);
      tick;
    end
    chk("tmo_fault", 32'({state, fault}), 4'b1111);
    chk("tmo_wr", 32'(wr), 0);
    imem_ready = 1'b1;
    tick;
    chk("tmo_sticky", 32'({state, fault, wr}), 13'b1111000000000);
    reset = 1'b1;
    #1;
    chk("tmo_rst_out", 32'({fault, wr}), 0);
    tick;
    reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("tmo_recover", 32'({state, imem_req, fault}), 5'b00010);

    // reset during sw MEM
    opcode = 3'd5;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    tick; tick;
    chk("sw_exec_srcb", 32'(alu_src_b), 2);
    tick;
    chk("sw_mem", 32'({state, mem_write, mem_read, dmem_req}), 6'b011101);
    reset = 1'b1;
    #1;
    chk("sw_rst_drop", 32'({mem_write, dmem_req}), 0);
    tick;
    reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("sw_restart", 32'({state, imem_req, mem_write}), 5'b00010);
    tick;
    chk("sw_no_write", 32'({state, mem_write, reg_write, dmem_req}), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mips16_multicycle_ctrl.md
# mips16_multicycle_ctrl

Multi-cycle control unit for the 16-bit MIPS core, replacing the single-cycle combinational decoder plus ALU-control pair. It sequences FETCH/DECODE/EXEC/MEM/WB states, waits on ready handshakes from instruction and data memory, and drives all datapath strobes. Its parameters cover opcode, funct and ALU-control widths, plus the memory wait timeout. It sits between the instruction register (IR) and the shared-ALU, single-memory-port datapath.

## Interface
- OPCODE_W, 3, opcode field width
- FUNCT_W, 4, R-type funct field width
- ALUC_W, 3, ALU control code width
- WAIT_MAX, 15, max wait cycles for a memory ready; 0 disables timeout
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- opcode  in  OPCODE_W  IR opcode field, stable from the cycle after IR load
- funct  in  FUNCT_W  IR funct field
- imem_ready  in  1  instruction fetch complete this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req, mem_read, mem_write  out  1  data access request and direction
- ir_write, pc_write, pc_write_eq, pc_write_ne  out  1  IR load; unconditional PC load; PC load on ALU zero / not-zero
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr)
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 2, 10 sext imm, 11 sext imm<<1
- alu_ctrl  out  ALUC_W  000 add, 001 sub, 010 and, 011 or, 100 slt
- reg_dst, mem_to_reg, reg_write  out  1  register-file write controls
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse on an undefined funct
- fault  out  1  sticky memory-timeout flag
- state  out  3  current state, for debug

## Operation
- Opcodes: 000 R, 001 slti, 010 j, 011 bne, 100 lw, 101 sw, 110 beq, 111 addi.
- Funct: 0 add, 1 sub, 2 and, 3 or, 4 slt, 8 jr. Any other funct is illegal.
- FETCH: imem_req=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add.
  - When imem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target captured into ALUOut). Next state:
  - beq/bne: BRANCH.
  - j: JUMP.
  - R with funct 8: JUMP.
  - R with illegal funct: FETCH, illegal=1, instr_done=1.
  - All others: EXEC.
- EXEC: alu_src_a=1.
  - alu_src_b=00 for R, 10 otherwise.
  - alu_ctrl: funct decode for R; slt for slti; add for addi/lw/sw.
  - lw/sw: go to MEM; else go to WB.
- MEM: dmem_req=1, mem_read=lw, mem_write=sw, held until dmem_ready.
  - On ready, lw goes to WB.
  - On ready, sw goes to FETCH with instr_done=1.
- WB: reg_write=1, reg_dst=(R), mem_to_reg=(lw); go to FETCH with instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=sub, pc_src=01.
  - pc_write_eq=beq, pc_write_ne=bne; go to FETCH with instr_done=1.
- JUMP: pc_write=1, pc_src=10 (j) or 11 (jr); go to FETCH with instr_done=1.
- FAULT: all strobes 0, fault=1. Exited only by reset.
- Wait counter:
  - Clears on entry to FETCH and MEM.
  - Increments each cycle while the relevant ready is low.
  - When WAIT_MAX≠0 and the count reaches WAIT_MAX with ready still low, go to FAULT next cycle.

## Timing
- Registers are the state, the wait counter and fault. All other outputs are combinational from state, opcode and funct (Moore-style; no ready→strobe paths except the FETCH/MEM exit strobes).
- While reset is high, every output is 0 and state=FETCH. imem_req first goes high in the first cycle after reset deasserts. Reset mid-access aborts with no write strobe.
- Latency with ready asserted in the request cycle:
  - R/addi/slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne/j/jr: 3 cycles.
  - Each wait cycle adds 1.
- A ready that arrives in the same cycle the counter hits WAIT_MAX is accepted; no fault.
- Ready seen outside FETCH/MEM is ignored.

## Structure
- Package mips16_pkg holds:
  - opcode and funct localparams;
  - ALU control codes;
  - pc_src and alu_src_b encodings;
  - state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, FAULT=7.
- Sub-module mips16_alu_decoder: combinational mapping of {op class, funct} to alu_ctrl plus an illegal flag.

## Test plan
- add (op 000, funct 0), both readies tied high: states 0,1,2,4,0; reg_write=1 and reg_dst=1 only in cycle 4; instr_done in cycle 4.
- lw (100), dmem_ready held low 3 cycles: MEM lasts 4 cycles with mem_read=1; WB asserts mem_to_reg=1 and reg_write=1; total 8 cycles.
- beq (110) then bne (011): BRANCH asserts alu_ctrl=001 with pc_write_eq=1 (beq) or pc_write_ne=1 (bne), pc_src=01, and no reg_write.
- jr (R, funct 8): JUMP asserts pc_src=11, pc_write=1. Funct 5: illegal pulse in DECODE, no writes, back to FETCH.
- WAIT_MAX=4, imem_ready low forever: fault=1 after 5 FETCH cycles; all strobes 0; reset clears fault, then state=FETCH with imem_req=1.
- reset asserted during MEM of sw: mem_write drops in the same cycle; after release, a fetch restarts with no spurious writes.
